// File: rtl/ascii_disp_pkg.sv
// Shared definitions for the ASCII scrolling display controller.
// Optional feature macro: ASCII_SCROLL_PAUSE_EN (adds the PAUSE state).
package ascii_disp_pkg;

   localparam logic [6:0] ASCII_SPACE = 7'h20;

   localparam int DEF_DIGITS  = 4;
   localparam int DEF_DEPTH   = 16;
   localparam int DEF_MUX_DIV = 1024;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1
`ifdef ASCII_SCROLL_PAUSE_EN
      ,PAUSE = 2'd2
`endif
   } state_t;

   // Counter width able to hold 0..n-1, never narrower than one bit.
   function automatic int cnt_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/ascii_mux_timer.sv
// Digit-multiplex timing: slot counter (0..MUX_DIV-1) and digit index.
// A frame is DIGITS slots. Not affected by ASCII_SCROLL_PAUSE_EN.
module ascii_mux_timer
   import ascii_disp_pkg::*;
#(
   parameter int DIGITS  = DEF_DIGITS,
   parameter int MUX_DIV = DEF_MUX_DIV
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       run,
   input  logic                       clr,
   output logic                       slot_tick,
   output logic                       frame_tick,
   output logic [cnt_w(DIGITS)-1:0]   digit
);

   localparam int SW = cnt_w(MUX_DIV);
   localparam int DW = cnt_w(DIGITS);

   logic [SW-1:0] slot_cnt_q;
   logic [DW-1:0] digit_q;

   assign slot_tick  = run && (slot_cnt_q == SW'(MUX_DIV - 1));
   assign frame_tick = slot_tick && (digit_q == DW'(DIGITS - 1));
   assign digit      = digit_q;

   // Slot counter and digit index; synchronous clear has priority over counting.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         slot_cnt_q <= '0;
         digit_q    <= '0;
      end else if (clr) begin
         slot_cnt_q <= '0;
         digit_q    <= '0;
      end else if (slot_tick) begin
         slot_cnt_q <= '0;
         digit_q    <= frame_tick ? '0 : digit_q + DW'(1);
      end else if (run) begin
         slot_cnt_q <= slot_cnt_q + SW'(1);
      end
   end

endmodule

// File: rtl/ascii_scroll_ctrl.sv
// Scrolling ASCII message controller for a multiplexed 7-segment display.
// Optional feature macro: ASCII_SCROLL_PAUSE_EN (hold window at pos 0 after each wrap).
module ascii_scroll_ctrl
   import ascii_disp_pkg::*;
#(
   parameter int DIGITS  = DEF_DIGITS,
   parameter int DEPTH   = DEF_DEPTH,
   parameter int MUX_DIV = DEF_MUX_DIV
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       wr_en,
   input  logic [$clog2(DEPTH)-1:0]   wr_addr,
   input  logic [6:0]                 wr_data,
   input  logic [$clog2(DEPTH):0]     msg_len,
   input  logic [7:0]                 scroll_div,
   input  logic                       start,
   input  logic                       stop,
   output logic [6:0]                 char_out,
   output logic [DIGITS-1:0]          dig_sel,
   output logic                       busy,
   output logic                       wrap
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;
   localparam int DW = cnt_w(DIGITS);

   state_t          state_q, state_n;
   logic [6:0]      msg_buf [DEPTH];
   logic [LW-1:0]   len_q;
   logic [AW-1:0]   pos_q;
   logic [7:0]      frame_cnt_q;
   logic            load_q;
   logic            slot_tick, frame_tick;
   logic [DW-1:0]   digit;
   logic            scrolling, step, pos_wrap, tmr_clr;
   logic [LW-1:0]   sum;
   logic [AW-1:0]   rd_idx;
   logic [6:0]      win_char;

   assign busy      = (state_q != IDLE);
   assign scrolling = (len_q > LW'(DIGITS));
   assign step      = frame_tick && (frame_cnt_q == scroll_div);
   assign pos_wrap  = (state_q == RUN) && scrolling && step &&
                      ({1'b0, pos_q} == len_q - LW'(1));
   assign tmr_clr   = (state_q == IDLE) || start || stop;

   ascii_mux_timer #(
      .DIGITS  (DIGITS),
      .MUX_DIV (MUX_DIV)
   ) u_timer (
      .clk        (clk),
      .rst        (rst),
      .run        (busy),
      .clr        (tmr_clr),
      .slot_tick  (slot_tick),
      .frame_tick (frame_tick),
      .digit      (digit)
   );

   // Message buffer: writable in any state, cleared to spaces on reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int unsigned i = 0; i < DEPTH; i++) msg_buf[i] <= ASCII_SPACE;
      end else if (wr_en) begin
         msg_buf[wr_addr] <= wr_data;
      end
   end

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_n;
   end

   // Next-state logic: stop beats start; start with empty message idles.
   always_comb begin
      state_n = state_q;
      if (stop)
         state_n = IDLE;
      else if (start)
         state_n = (msg_len != '0) ? RUN : IDLE;
`ifdef ASCII_SCROLL_PAUSE_EN
      else if (pos_wrap)
         state_n = PAUSE;
      else if ((state_q == PAUSE) && step)
         state_n = RUN;
`endif
   end

   // Scroll position, frame counter, wrap pulse and slot-load strobe.
   // load_q marks the first cycle of each slot, so outputs follow one clock later.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         len_q       <= '0;
         pos_q       <= '0;
         frame_cnt_q <= '0;
         wrap        <= 1'b0;
         load_q      <= 1'b0;
      end else begin
         wrap   <= pos_wrap && !start && !stop;
         load_q <= (state_n != IDLE) && (slot_tick || start);
         if (state_n == IDLE) begin
            pos_q       <= '0;
            frame_cnt_q <= '0;
         end else if (start) begin
            len_q       <= msg_len;
            pos_q       <= '0;
            frame_cnt_q <= '0;
         end else if (frame_tick) begin
            frame_cnt_q <= step ? '0 : frame_cnt_q + 8'd1;
            if ((state_q == RUN) && scrolling && step)
               pos_q <= pos_wrap ? '0 : pos_q + AW'(1);
         end
      end
   end

   // Window lookup: circular when scrolling, else static with space padding.
   // pos < len and digit < len when scrolling, so one subtraction suffices.
   always_comb begin
      sum      = {1'b0, pos_q} + LW'(digit);
      rd_idx   = AW'((sum >= len_q) ? sum - len_q : sum);
      win_char = (scrolling || (LW'(digit) < len_q)) ? msg_buf[rd_idx] : ASCII_SPACE;
   end

   // Registered display outputs, blanked whenever the block is (or is going) idle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         char_out <= ASCII_SPACE;
         dig_sel  <= '0;
      end else if (state_n == IDLE) begin
         char_out <= ASCII_SPACE;
         dig_sel  <= '0;
      end else if (load_q) begin
         char_out <= win_char;
         dig_sel  <= DIGITS'(1) << digit;
      end
   end

endmodule

// File: tb/tb_ascii_scroll_ctrl.sv
// Self-checking bench for ascii_scroll_ctrl (DIGITS=4, DEPTH=16, MUX_DIV=4).
// Honours ASCII_SCROLL_PAUSE_EN in its reference model.
module tb_ascii_scroll_ctrl;

   localparam int DIGITS  = 4;
   localparam int DEPTH   = 16;
   localparam int MUX_DIV = 4;

   logic       clk = 1'b0;
   logic       rst;
   logic       wr_en;
   logic [3:0] wr_addr;
   logic [6:0] wr_data;
   logic [4:0] msg_len;
   logic [7:0] scroll_div;
   logic       start;
   logic       stop;
   logic [6:0] char_out;
   logic [3:0] dig_sel;
   logic       busy;
   logic       wrap;

   ascii_scroll_ctrl #(
      .DIGITS  (DIGITS),
      .DEPTH   (DEPTH),
      .MUX_DIV (MUX_DIV)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .wr_en      (wr_en),
      .wr_addr    (wr_addr),
      .wr_data    (wr_data),
      .msg_len    (msg_len),
      .scroll_div (scroll_div),
      .start      (start),
      .stop       (stop),
      .char_out   (char_out),
      .dig_sel    (dig_sel),
      .busy       (busy),
      .wrap       (wrap)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [3:0] dig;
      logic [6:0] ch;
   } slot_t;

   slot_t      sb[$];
   logic [6:0] exp_buf [DEPTH];
   int         errors = 0;
   int         checks = 0;
   int         cyc = 0;
   int         wrap_cnt = 0;
   int         wb;
   int         last_chg;
   logic [3:0] prev_dig;

   always @(posedge clk) begin
      cyc++;
      if (wrap === 1'b1) wrap_cnt++;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
      checks++;
      assert (got === want) else begin
         errors++;
         $error("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
      end
   endtask

   function automatic logic [6:0] exp_ch(input int p, input int d, input int len);
      if (len > DIGITS) return exp_buf[(p + d) % len];
      return (d < len) ? exp_buf[d] : 7'h20;
   endfunction

   // Reference model of the scroll position, frame by frame.
   task automatic push_frames(input int n, input int len, input int sd);
      int p = 0;
      int fc = 0;
      bit paused = 1'b0;
      slot_t e;
      for (int f = 0; f < n; f++) begin
         for (int d = 0; d < DIGITS; d++) begin
            e.dig = 4'(1 << d);
            e.ch  = exp_ch(p, d, len);
            sb.push_back(e);
         end
         if (len > DIGITS) begin
            if (fc == sd) begin
               fc = 0;
               if (paused) paused = 1'b0;
               else if (p == len - 1) begin
                  p = 0;
`ifdef ASCII_SCROLL_PAUSE_EN
                  paused = 1'b1;
`endif
               end else p++;
            end else fc++;
         end
      end
   endtask

   task automatic drain(input int n, input string tag);
      slot_t e;
      int deadline;
      for (int k = 0; k < n; k++) begin
         deadline = cyc + 20;
         do @(negedge clk); while (dig_sel === prev_dig && cyc < deadline);
         check({tag, " timeout"}, 32'(dig_sel !== prev_dig), 1);
         e = (sb.size() > 0) ? sb.pop_front() : '1;
         check({tag, " dig_sel"}, 32'(dig_sel), 32'(e.dig));
         check({tag, " char_out"}, 32'(char_out), 32'(e.ch));
         if (last_chg >= 0) check({tag, " cadence"}, cyc - last_chg, MUX_DIV);
         last_chg = cyc;
         prev_dig = dig_sel;
      end
   endtask

   task automatic wr(input int a, input logic [6:0] d);
      @(negedge clk);
      wr_en = 1'b1; wr_addr = 4'(a); wr_data = d;
      exp_buf[a] = d;
      @(negedge clk);
      wr_en = 1'b0;
   endtask

   task automatic wr_str(input int base, input string s);
      for (int i = 0; i < s.len(); i++) wr(base + i, 7'(s[i]));
   endtask

   task automatic do_start(input int len);
      msg_len = 5'(len);
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
      prev_dig = dig_sel;
      last_chg = -1;
   endtask

   task automatic do_stop();
      @(negedge clk); stop = 1'b1;
      @(negedge clk); stop = 1'b0;
   endtask

   initial begin
      rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0; msg_len = '0;
      scroll_div = '0; start = 1'b0; stop = 1'b0; last_chg = -1; prev_dig = '0;
      for (int i = 0; i < DEPTH; i++) exp_buf[i] = 7'h20;
      repeat (3) @(negedge clk);
      check("reset char_out", 32'(char_out), 32'h20);
      check("reset dig_sel", 32'(dig_sel), 0);
      check("reset busy", 32'(busy), 0);
      check("reset wrap", 32'(wrap), 0);
      @(negedge clk); rst = 1'b0;

      // Scrolling message through a full wrap.
      wr_str(0, "HELLO WORLD");
      wb = wrap_cnt;
      push_frames(13, 11, 0);
      do_start(11);
      check("run busy", 32'(busy), 1);
      drain(52, "hello");
      check("hello wrap pulses", wrap_cnt - wb, 1);
      do_stop();
      check("stop busy", 32'(busy), 0);
      check("stop dig_sel", 32'(dig_sel), 0);
      check("stop char_out", 32'(char_out), 32'h20);

      // Slower scroll: two frames per step.
      scroll_div = 8'd1;
      push_frames(3, 11, 1);
      do_start(11);
      drain(12, "slow");
      do_stop();
      scroll_div = 8'd0;

      // Short static message.
      wr_str(0, "OK");
      wb = wrap_cnt;
      push_frames(3, 2, 0);
      do_start(2);
      drain(12, "static");
      check("static wrap pulses", wrap_cnt - wb, 0);

      // start and stop together while running.
      @(negedge clk); start = 1'b1; stop = 1'b1;
      @(negedge clk); start = 1'b0; stop = 1'b0;
      check("start+stop busy", 32'(busy), 0);
      check("start+stop dig_sel", 32'(dig_sel), 0);
      sb.delete();

      // Empty message never leaves idle.
      do_start(0);
      check("len0 busy now", 32'(busy), 0);
      repeat (10) @(negedge clk);
      check("len0 busy later", 32'(busy), 0);
      check("len0 dig_sel", 32'(dig_sel), 0);

      // Write during the digit-1 slot: old code stays until the next digit-1 slot.
      push_frames(1, 2, 0);
      do_start(2);
      drain(2, "wr pre");
      wr(1, 7'h41);
      check("wr current slot char", 32'(char_out), 32'h4B);
      check("wr current slot dig", 32'(dig_sel), 32'b0010);
      drain(2, "wr rest");
      push_frames(1, 2, 0);
      drain(4, "wr post");
      do_stop();

      // Reset in the middle of scrolling.
      do_start(11);
      repeat (9) @(negedge clk);
      rst = 1'b1;
      #1;
      check("async rst dig_sel", 32'(dig_sel), 0);
      check("async rst char_out", 32'(char_out), 32'h20);
      check("async rst busy", 32'(busy), 0);
      for (int i = 0; i < DEPTH; i++) exp_buf[i] = 7'h20;
      @(negedge clk); rst = 1'b0;
      push_frames(13, 16, 0);
      do_start(16);
      drain(52, "cleared buf");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
